// File: rtl/bpsk_code_sequencer_if.sv
// Signal bundle between the processor-side configuration registers and the BPSK chip sequencer.
// The master modport is the configuration/control side; the slave modport is the sequencer.
interface bpsk_code_sequencer_if #(
    parameter int unsigned CODE_MAX_LEN = 64,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned PRI_W        = 32,
    parameter int unsigned CNT_W        = 16
);
    logic [CODE_MAX_LEN-1:0] code_word;
    logic [6:0]              code_len;
    logic [DIV_W-1:0]        chip_div;
    logic [PRI_W-1:0]        pri_period;
    logic [CNT_W-1:0]        num_pulses;
    logic                    start;
    logic                    abort;

    logic                    cod;
    logic                    tx_en;
    logic                    chip_strobe;
    logic                    pulse_start;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;
    logic [CNT_W-1:0]        pulse_cnt;

    modport master (
        output code_word, code_len, chip_div, pri_period, num_pulses, start, abort,
        input  cod, tx_en, chip_strobe, pulse_start, busy, done, cfg_err, pulse_cnt
    );

    modport slave (
        input  code_word, code_len, chip_div, pri_period, num_pulses, start, abort,
        output cod, tx_en, chip_strobe, pulse_start, busy, done, cfg_err, pulse_cnt
    );
endinterface

// File: rtl/bpsk_code_sequencer.sv
// BPSK pulse/chip scheduler: plays a latched binary phase code MSB-first, one burst per PRI,
// for a programmable number of bursts (or continuously until abort). All outputs registered.
module bpsk_code_sequencer #(
    parameter int unsigned CODE_MAX_LEN = 64,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned PRI_W        = 32,
    parameter int unsigned CNT_W        = 16
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    bpsk_code_sequencer_if.slave seq_io
);
    localparam int unsigned IDX_W  = (CODE_MAX_LEN > 1) ? $clog2(CODE_MAX_LEN) : 1;
    localparam int unsigned PROD_W = 7 + DIV_W + 1;
    localparam int unsigned CMP_W  = ((PRI_W > PROD_W) ? PRI_W : PROD_W) + 1;

    typedef enum logic [1:0] {StIdle, StChips, StGap} state_e;

    state_e                  state_q, state_d;
    logic [CODE_MAX_LEN-1:0] code_q, code_d;
    logic [6:0]              len_q, len_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [PRI_W-1:0]        pri_q, pri_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic [PRI_W-1:0]        pri_cnt_q, pri_cnt_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [6:0]              chip_idx_q, chip_idx_d;
    logic                    cod_q, cod_d;
    logic                    tx_en_q, tx_en_d;
    logic                    chip_strobe_q, chip_strobe_d;
    logic                    pulse_start_q, pulse_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]        pulse_cnt_q, pulse_cnt_d;

    logic [PROD_W-1:0]       burst_len;
    logic                    cfg_bad;
    logic [IDX_W-1:0]        first_pos_in, first_pos, next_pos;
    logic [CNT_W-1:0]        cnt_inc;

    // Burst length is formed at full width so a large chip_div cannot wrap the check.
    always_comb begin
        burst_len = PROD_W'(seq_io.code_len) * (PROD_W'(seq_io.chip_div) + PROD_W'(1));
        cfg_bad   = (seq_io.code_len == 7'd0)
                 || (32'(seq_io.code_len) > CODE_MAX_LEN)
                 || (CMP_W'(seq_io.pri_period) < CMP_W'(burst_len) + CMP_W'(1));
    end

    always_comb begin
        first_pos_in = IDX_W'(seq_io.code_len - 7'd1);
        first_pos    = IDX_W'(len_q - 7'd1);
        next_pos     = IDX_W'(len_q - chip_idx_q - 7'd2);
        cnt_inc      = (pulse_cnt_q == '1) ? pulse_cnt_q : pulse_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        len_d         = len_q;
        div_d         = div_q;
        pri_d         = pri_q;
        num_d         = num_q;
        pri_cnt_d     = pri_cnt_q;
        div_cnt_d     = div_cnt_q;
        chip_idx_d    = chip_idx_q;
        cod_d         = cod_q;
        tx_en_d       = tx_en_q;
        chip_strobe_d = 1'b0;
        pulse_start_d = 1'b0;
        done_d        = 1'b0;
        cfg_err_d     = cfg_err_q;
        pulse_cnt_d   = pulse_cnt_q;

        if (seq_io.abort) begin
            state_d = StIdle;
            cod_d   = 1'b1;
            tx_en_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seq_io.start) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            code_d        = seq_io.code_word;
                            len_d         = seq_io.code_len;
                            div_d         = seq_io.chip_div;
                            pri_d         = seq_io.pri_period;
                            num_d         = seq_io.num_pulses;
                            cfg_err_d     = 1'b0;
                            pulse_cnt_d   = CNT_W'(1);
                            state_d       = StChips;
                            pri_cnt_d     = '0;
                            div_cnt_d     = '0;
                            chip_idx_d    = '0;
                            tx_en_d       = 1'b1;
                            cod_d         = seq_io.code_word[first_pos_in];
                            pulse_start_d = 1'b1;
                            chip_strobe_d = 1'b1;
                        end
                    end
                end
                StChips: begin
                    pri_cnt_d = pri_cnt_q + PRI_W'(1);
                    if (div_cnt_q == div_q) begin
                        div_cnt_d = '0;
                        if (chip_idx_q == len_q - 7'd1) begin
                            state_d = StGap;
                            tx_en_d = 1'b0;
                            cod_d   = 1'b1;
                        end else begin
                            chip_idx_d    = chip_idx_q + 7'd1;
                            cod_d         = code_q[next_pos];
                            chip_strobe_d = 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                StGap: begin
                    if (pri_cnt_q == pri_q - PRI_W'(1)) begin
                        if ((num_q == '0) || (pulse_cnt_q < num_q)) begin
                            state_d       = StChips;
                            pri_cnt_d     = '0;
                            div_cnt_d     = '0;
                            chip_idx_d    = '0;
                            tx_en_d       = 1'b1;
                            cod_d         = code_q[first_pos];
                            pulse_start_d = 1'b1;
                            chip_strobe_d = 1'b1;
                            pulse_cnt_d   = cnt_inc;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pri_cnt_d = pri_cnt_q + PRI_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            code_q        <= '0;
            len_q         <= '0;
            div_q         <= '0;
            pri_q         <= '0;
            num_q         <= '0;
            pri_cnt_q     <= '0;
            div_cnt_q     <= '0;
            chip_idx_q    <= '0;
            cod_q         <= 1'b1;
            tx_en_q       <= 1'b0;
            chip_strobe_q <= 1'b0;
            pulse_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            pulse_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            len_q         <= len_d;
            div_q         <= div_d;
            pri_q         <= pri_d;
            num_q         <= num_d;
            pri_cnt_q     <= pri_cnt_d;
            div_cnt_q     <= div_cnt_d;
            chip_idx_q    <= chip_idx_d;
            cod_q         <= cod_d;
            tx_en_q       <= tx_en_d;
            chip_strobe_q <= chip_strobe_d;
            pulse_start_q <= pulse_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            pulse_cnt_q   <= pulse_cnt_d;
        end
    end

    assign seq_io.cod         = cod_q;
    assign seq_io.tx_en       = tx_en_q;
    assign seq_io.chip_strobe = chip_strobe_q;
    assign seq_io.pulse_start = pulse_start_q;
    assign seq_io.busy        = busy_q;
    assign seq_io.done        = done_q;
    assign seq_io.cfg_err     = cfg_err_q;
    assign seq_io.pulse_cnt   = pulse_cnt_q;
endmodule
